// File: rtl/cache_ctrl_wb.sv
// Cache miss/write controller: sequences victim write-back, line fill and array
// update around a core request, in write-through or write-back/allocate mode.
module cache_ctrl_wb #(
    parameter int RD_LAT     = 2,
    parameter int WR_LAT     = 2,
    parameter int WRITE_BACK = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en_R,
    input  logic en_W,
    input  logic hit,
    input  logic dirty,
    output logic Read_mem,
    output logic Write_mem,
    output logic Valid_enable,
    output logic Tag_enable,
    output logic Data_enable,
    output logic Dirty_enable,
    output logic Dirty_value,
    output logic sel_mem_core,
    output logic sel_victim,
    output logic stall
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB,
        S_FILL,
        S_UPDATE
    } state_t;

    localparam bit         WB_MODE = (WRITE_BACK != 0);
    localparam logic [3:0] RD_INIT = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_INIT = 4'(WR_LAT - 1);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       req_r;
    logic       req_w;
    logic       miss;

    // Simultaneous read and write is an illegal request and is dropped entirely.
    assign req_r = en_R & ~en_W;
    assign req_w = en_W & ~en_R;
    assign miss  = (req_r & ~hit) | (WB_MODE & req_w & ~hit);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (miss) begin
                        if (WB_MODE && dirty) begin
                            state_q <= S_WB;
                            cnt_q   <= WR_INIT;
                        end else begin
                            state_q <= S_FILL;
                            cnt_q   <= RD_INIT;
                        end
                    end
                end
                S_WB: begin
                    if (cnt_q == '0) begin
                        state_q <= S_FILL;
                        cnt_q   <= RD_INIT;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_FILL: begin
                    if (cnt_q == '0) state_q <= S_UPDATE;
                    else             cnt_q   <= cnt_q - 4'd1;
                end
                S_UPDATE: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs are decoded combinationally: hits must be served in the request
    // cycle and reset must blank them immediately.
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        Read_mem     = 1'b0;
        Write_mem    = 1'b0;
        Valid_enable = 1'b0;
        Tag_enable   = 1'b0;
        Data_enable  = 1'b0;
        Dirty_enable = 1'b0;
        Dirty_value  = 1'b0;
        sel_mem_core = 1'b0;
        sel_victim   = 1'b0;
        stall        = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    stall = miss;
                    if (req_w && hit) begin
                        Data_enable  = 1'b1;
                        sel_mem_core = 1'b1;
                        Dirty_enable = WB_MODE;
                        Dirty_value  = WB_MODE;
                        Write_mem    = ~WB_MODE;
                    end else if (req_w && !WB_MODE) begin
                        Write_mem = 1'b1;
                    end
                end
                S_WB: begin
                    Write_mem  = 1'b1;
                    sel_victim = 1'b1;
                    stall      = 1'b1;
                end
                S_FILL: begin
                    Read_mem = 1'b1;
                    stall    = 1'b1;
                end
                S_UPDATE: begin
                    Valid_enable = 1'b1;
                    Tag_enable   = 1'b1;
                    Data_enable  = 1'b1;
                    Dirty_enable = WB_MODE;
                    stall        = 1'b1;
                end
                default: stall = 1'b0;
            endcase
        end
    end

endmodule
